// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register scoreboard: pending-write tracking, ID stall and bypass select
// Optional feature macro: SCOREBOARD_BYPASS_EN (forward results whose countdown has expired)
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 7,
    parameter int MAX_OUT = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       id_valid,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [AW-1:0]              id_rs1,
    input  logic [AW-1:0]              id_rs2,
    input  logic                       iss_valid,
    input  logic                       iss_we,
    input  logic [AW-1:0]              iss_rd,
    input  logic [3:0]                 iss_lat,
    input  logic                       wb_valid,
    input  logic [AW-1:0]              wb_rd,
    output logic                       stall,
    output logic                       iss_ready,
    output logic                       fwd_a,
    output logic                       fwd_b,
    output logic                       err_ovf,
    output logic [$clog2(MAX_OUT):0]   outstanding
);
    localparam int CW = $clog2(MAX_LAT + 1);
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [NREG-1:0] busy;
    logic [CW-1:0]   cnt [NREG];
    logic [CW-1:0]   lat_c;
    logic            do_iss;
    logic            iss_new;
    logic            wb_clr;
    logic            src1_busy;
    logic            src2_busy;
    logic            haz1;
    logic            haz2;

    assign lat_c     = (int'(iss_lat) > MAX_LAT) ? CW'(MAX_LAT) : CW'(iss_lat);
    assign iss_ready = (outstanding < OW'(MAX_OUT));
    assign do_iss    = iss_valid & iss_we & (iss_rd != '0) & iss_ready;
    assign iss_new   = do_iss & ~busy[iss_rd];
    // A same-cycle issue to the writeback register keeps the entry alive
    assign wb_clr    = wb_valid & (wb_rd != '0) & busy[wb_rd] & ~(do_iss & (iss_rd == wb_rd));

    assign src1_busy = id_valid & id_rs1_used & (id_rs1 != '0) & busy[id_rs1];
    assign src2_busy = id_valid & id_rs2_used & (id_rs2 != '0) & busy[id_rs2];

`ifdef SCOREBOARD_BYPASS_EN
    assign haz1  = src1_busy & (cnt[id_rs1] != '0);
    assign haz2  = src2_busy & (cnt[id_rs2] != '0);
    assign fwd_a = src1_busy & (cnt[id_rs1] == '0);
    assign fwd_b = src2_busy & (cnt[id_rs2] == '0);
`else
    assign haz1  = src1_busy;
    assign haz2  = src2_busy;
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    assign stall = haz1 | haz2 | (id_valid & ~iss_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy        <= '0;
            for (int i = 0; i < NREG; i++) cnt[i] <= '0;
            outstanding <= '0;
            err_ovf     <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (do_iss && (iss_rd == AW'(i))) begin
                    busy[i] <= 1'b1;
                    cnt[i]  <= lat_c;
                end else if (wb_clr && (wb_rd == AW'(i))) begin
                    busy[i] <= 1'b0;
                    cnt[i]  <= '0;
                end else if (busy[i] && (cnt[i] != '0)) begin
                    cnt[i]  <= cnt[i] - CW'(1);
                end
            end
            case ({iss_new, wb_clr})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (iss_valid && !iss_ready) err_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rstn;
    logic       id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2;
    logic       iss_valid, iss_we;
    logic [4:0] iss_rd;
    logic [3:0] iss_lat;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       stall, iss_ready, fwd_a, fwd_b, err_ovf;
    logic [2:0] outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_scoreboard dut (
        .clk(clk), .rstn(rstn),
        .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd), .iss_lat(iss_lat),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .stall(stall), .iss_ready(iss_ready), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .err_ovf(err_ovf), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_rs1 = 0; id_rs2 = 0;
        iss_valid = 0; iss_we = 0; iss_rd = 0; iss_lat = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic test_reset();
        idle();
        rstn = 0;
        #2;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", iss_ready); end
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL reset_out: got %0d expected 0", outstanding); end
        n_tests++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", err_ovf); end
        n_tests++; if ({fwd_a, fwd_b} !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %b expected 00", {fwd_a, fwd_b}); end
        tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_alu_dep();
        iss_valid = 1; iss_we = 1; iss_rd = 5; iss_lat = 0;
        tick();
        idle();
        id_valid = 1; id_rs1_used = 1; id_rs1 = 5;
        #1;
        n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL alu_out: got %0d expected 1", outstanding); end
`ifdef SCOREBOARD_BYPASS_EN
        n_tests++; if ({stall, fwd_a} !== 2'b01) begin n_fail++; $display("FAIL alu_bypass: got stall,fwd_a=%b expected 01", {stall, fwd_a}); end
`else
        n_tests++; if ({stall, fwd_a} !== 2'b10) begin n_fail++; $display("FAIL alu_nobypass: got stall,fwd_a=%b expected 10", {stall, fwd_a}); end
        tick();
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL alu_hold: got %b expected 1", stall); end
`endif
        wb_valid = 1; wb_rd = 5;
        tick();
        wb_valid = 0;
        #1;
        n_tests++; if ({stall, fwd_a} !== 2'b00) begin n_fail++; $display("FAIL alu_after_wb: got %b expected 00", {stall, fwd_a}); end
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL alu_out_wb: got %0d expected 0", outstanding); end
        idle();
    endtask

    task automatic test_load_use();
        iss_valid = 1; iss_we = 1; iss_rd = 7; iss_lat = 1;
        tick();
        idle();
        id_valid = 1; id_rs2_used = 1; id_rs2 = 7;
        #1;
        n_tests++; if ({stall, fwd_b} !== 2'b10) begin n_fail++; $display("FAIL load_first: got stall,fwd_b=%b expected 10", {stall, fwd_b}); end
        tick();
`ifdef SCOREBOARD_BYPASS_EN
        n_tests++; if ({stall, fwd_b} !== 2'b01) begin n_fail++; $display("FAIL load_second: got stall,fwd_b=%b expected 01", {stall, fwd_b}); end
`else
        n_tests++; if ({stall, fwd_b} !== 2'b10) begin n_fail++; $display("FAIL load_second: got stall,fwd_b=%b expected 10", {stall, fwd_b}); end
`endif
        wb_valid = 1; wb_rd = 7;
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL load_out: got %0d expected 0", outstanding); end
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) begin
            iss_valid = 1; iss_we = 1; iss_rd = 5'(r); iss_lat = 4'd12;
            tick();
        end
        idle();
        id_valid = 1; id_rs1 = 20;
        #1;
        n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL full_out: got %0d expected 4", outstanding); end
        n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", iss_ready); end
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL full_stall: got %b expected 1", stall); end
        id_valid = 0;
        iss_valid = 1; iss_we = 1; iss_rd = 6; iss_lat = 2;
        tick();
        idle();
        #1;
        n_tests++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", err_ovf); end
        n_tests++; if (outstanding !== 3'd4) begin n_fail++; $display("FAIL ovf_out: got %0d expected 4", outstanding); end
        id_valid = 1; id_rs1_used = 1; id_rs1 = 6;
        // register 6 was dropped; only the full-queue term may stall
        #1;
        n_tests++; if (dut.busy[6] !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got busy=%b expected 0", dut.busy[6]); end
        idle();
        for (int r = 1; r <= 4; r++) begin
            wb_valid = 1; wb_rd = 5'(r);
            tick();
        end
        idle();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL drain_out: got %0d expected 0", outstanding); end
        n_tests++; if ({iss_ready, err_ovf} !== 2'b11) begin n_fail++; $display("FAIL drain_ready_ovf: got %b expected 11", {iss_ready, err_ovf}); end
    endtask

    task automatic test_same_cycle();
        iss_valid = 1; iss_we = 1; iss_rd = 9; iss_lat = 5;
        tick();
        wb_valid = 1; wb_rd = 9; iss_lat = 3;
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 3'd1) begin n_fail++; $display("FAIL same_out: got %0d expected 1", outstanding); end
        n_tests++; if (dut.busy[9] !== 1'b1) begin n_fail++; $display("FAIL same_busy: got %b expected 1", dut.busy[9]); end
        n_tests++; if (dut.cnt[9] !== 3'd3) begin n_fail++; $display("FAIL same_cnt: got %0d expected 3", dut.cnt[9]); end
        tick();
        tick();
        n_tests++; if (dut.cnt[9] !== 3'd1) begin n_fail++; $display("FAIL countdown: got %0d expected 1", dut.cnt[9]); end
        tick();
        tick();
        n_tests++; if (dut.cnt[9] !== 3'd0) begin n_fail++; $display("FAIL count_sat: got %0d expected 0", dut.cnt[9]); end
        wb_valid = 1; wb_rd = 9;
        tick();
        idle();
        #1;
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL same_drain: got %0d expected 0", outstanding); end
    endtask

    task automatic test_zero_and_stray_wb();
        iss_valid = 1; iss_we = 1; iss_rd = 0; iss_lat = 2;
        tick();
        iss_valid = 1; iss_we = 0; iss_rd = 11; iss_lat = 2;
        wb_valid = 1; wb_rd = 3;
        tick();
        idle();
        id_valid = 1; id_rs1_used = 1; id_rs1 = 0; id_rs2_used = 1; id_rs2 = 11;
        #1;
        n_tests++; if ({stall, fwd_a, fwd_b} !== 3'b000) begin n_fail++; $display("FAIL zero_read: got %b expected 000", {stall, fwd_a, fwd_b}); end
        n_tests++; if (outstanding !== 3'd0) begin n_fail++; $display("FAIL zero_out: got %0d expected 0", outstanding); end
        idle();
    endtask

    task automatic test_reset_mid();
        iss_valid = 1; iss_we = 1; iss_rd = 12; iss_lat = 6;
        tick();
        idle();
        id_valid = 1; id_rs1_used = 1; id_rs1 = 12;
        tick();
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mid_stall: got %b expected 1", stall); end
        #1;
        rstn = 0;
        #1;
        n_tests++; if ({stall, iss_ready, err_ovf, outstanding} !== 6'b010000) begin
            n_fail++; $display("FAIL async_reset: got stall,ready,ovf,out=%b expected 010000", {stall, iss_ready, err_ovf, outstanding});
        end
        tick();
        rstn = 1;
        tick();
        n_tests++; if ({stall, fwd_a} !== 2'b00) begin n_fail++; $display("FAIL post_reset_read: got %b expected 00", {stall, fwd_a}); end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_dep();
        test_load_use();
        test_full();
        test_same_cycle();
        test_zero_and_stray_wb();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is hard-wired zero.
REQ-002 Parameter AW, default 5: register index width, equal to log2(NREG).
REQ-003 Parameter MAX_LAT, default 7: maximum result latency in cycles.
REQ-004 Parameter MAX_OUT, default 4: maximum number of outstanding pending writes.
REQ-005 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-007 Ports id_valid, id_rs1_used, id_rs2_used, input, 1 each: ID-stage instruction valid, and source-operand usage flags.
REQ-008 Ports id_rs1, id_rs2, input, AW each: ID-stage source register indices.
REQ-009 Ports iss_valid and iss_we, input, 1 each: an instruction leaves ID into EX this cycle; it writes a register.
REQ-010 Port iss_rd, input, AW: destination register of the issuing instruction.
REQ-011 Port iss_lat, input, 4: cycles until the issued result reaches the bypass network (0 = ALU, 1 = load, >1 = multi-cycle).
REQ-012 Ports wb_valid, input, 1, and wb_rd, input, AW: register writeback is completing this cycle.
REQ-013 Port stall, output, 1: freeze PC and IF/ID; insert a bubble into ID/EX.
REQ-014 Port iss_ready, output, 1: the scoreboard can accept another pending write.
REQ-015 Ports fwd_a and fwd_b, output, 1 each: rs1/rs2 is sourced from the bypass network instead of the register file.
REQ-016 Port err_ovf, output, 1: sticky flag for an issue attempted while iss_ready is 0.
REQ-017 Port outstanding, output, log2(MAX_OUT)+1: count of busy entries.

Function
REQ-018 Per-register state: busy bit plus countdown cnt, where cnt is log2(MAX_LAT+1) bits wide.
REQ-019 Issue: an issue with iss_valid=1, iss_we=1, iss_rd!=0 and iss_ready=1 sets busy[iss_rd]=1 and cnt[iss_rd]=min(iss_lat, MAX_LAT) on the next edge.
REQ-020 Issue to register 0, or with iss_we=0, changes no entry.
REQ-021 Countdown: every busy entry with cnt>0 that is not being issued this cycle decrements by 1 per cycle and saturates at 0.
REQ-022 Writeback: wb_valid clears busy[wb_rd] and cnt[wb_rd]; writeback to a non-busy register or to register 0 is ignored.
REQ-023 Issue and writeback to the same rd in the same cycle: the issue wins, leaving the entry busy with the new cnt.
REQ-024 WAW: an issue to an already-busy rd overwrites cnt and leaves outstanding unchanged.
REQ-025 Operand hazard: hazard_x = id_valid & id_rsx_used & (id_rsx!=0) & busy[id_rsx] & (cnt[id_rsx]!=0), evaluated for x = 1 and x = 2.
REQ-026 stall = hazard_1 | hazard_2 | (id_valid & ~iss_ready); stall is purely combinational from current state.
REQ-027 outstanding = number of busy entries; it is registered and updated in the same edge as the entries.
REQ-028 iss_ready = (outstanding < MAX_OUT).
REQ-029 An issue while iss_ready=0 is dropped and sets err_ovf; err_ovf is cleared only by reset.
REQ-030 Scoreboard lookup latency is 0 cycles: an issue at edge N is visible to ID hazard checks in cycle N+1.

Reset
REQ-031 Asserting rstn low immediately clears every busy bit, cnt, outstanding and err_ovf; stall, fwd_a and fwd_b read 0 and iss_ready reads 1.
REQ-032 Reset asserted mid-countdown discards all pending entries; no state survives.
REQ-033 Release of rstn is synchronised by the integrator; the first update occurs on the first rising edge after release.

Configuration
REQ-034 Macro SCOREBOARD_BYPASS_EN, when defined: fwd_x = id_valid & id_rsx_used & (id_rsx!=0) & busy[id_rsx] & (cnt[id_rsx]==0), and such operands do not stall.
REQ-035 Macro SCOREBOARD_BYPASS_EN, when undefined: fwd_a = fwd_b = 0 constantly, and the hazard term drops its cnt!=0 condition, so any busy source stalls until writeback.

Verification
REQ-036 Issue rd=5, lat=0; next cycle ID reads rs1=5 -> bypass: stall=0, fwd_a=1; no bypass: stall=1 until wb_rd=5.
REQ-037 Issue rd=7, lat=1 (load); next cycle ID reads rs2=7 -> stall=1 for exactly 1 cycle, then fwd_b=1 (bypass build).
REQ-038 Four issues to rd=1..4 with MAX_OUT=4 -> iss_ready=0 and outstanding=4; a fifth issue sets err_ovf=1 and outstanding stays 4.
REQ-039 Same-cycle issue rd=9 lat=3 and wb_rd=9 -> busy[9]=1, cnt=3, outstanding unchanged.
REQ-040 Issue to rd=0 followed by ID read of rs1=0 -> no stall, no fwd, outstanding=0.
REQ-041 rstn pulsed low during a 6-cycle countdown -> all outputs return to reset values asynchronously; a subsequent read of that register does not stall.
